avalon_bus_arbiter: RTL and testbench

- Shares the single Avalon-MM master port of the multicycle CPU between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Latches the winning command, drives the bus until `waitrequest` drops, and returns `readdata` plus a one-cycle `done` pulse to the owner.
- Sits between the CPU control/datapath and the testbench memory, replacing direct `address`/`read`/`write` muxing in the top level.

---
 rtl/avalon_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: shares the CPU's single Avalon-MM master port between fetch (port 0) and load/store (port 1).
// Latency: command on the bus one edge after req is sampled, done pulse on the edge waitrequest is low, 3 cycles minimum.
// Backpressure: the latched command is held stable while waitrequest is high; the non-owner waits in IDLE.
// Build option ARB_ROUND_ROBIN_EN: simultaneous requesters alternate instead of port 1 always winning.
module avalon_bus_arbiter #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_writedata,
    input  logic [BE_W-1:0]   p0_byteenable,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_readdata,
    input  logic              p1_req,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_writedata,
    input  logic [BE_W-1:0]   p1_byteenable,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_readdata,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,
    output logic              owner,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic [BE_W-1:0]   byteenable_q, byteenable_d;
    logic              owner_q, owner_d;
    logic              p0_done_q, p0_done_d;
    logic              p1_done_q, p1_done_d;
    logic [DATA_W-1:0] p0_readdata_q, p0_readdata_d;
    logic [DATA_W-1:0] p1_readdata_q, p1_readdata_d;
    logic              grant;
    logic              sel_write;
`ifdef ARB_ROUND_ROBIN_EN
    // 1 = port 0 preferred on a tie. Reset 0 keeps port 1 first; after a
    // completion it takes the owner's value, which prefers the other port.
    logic              rr_ptr_q, rr_ptr_d;
`endif

    // Pick the winning port from the current requests.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (p0_req && p1_req) begin
            grant = ~rr_ptr_q;
        end else begin
            grant = p1_req;
        end
`else
        grant = p1_req;
`endif
        sel_write = grant ? p1_write : p0_write;
    end

    // Next-state and datapath: latch the winner, hold until waitrequest drops, pulse done.
    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        read_d        = read_q;
        write_d       = write_q;
        writedata_d   = writedata_q;
        byteenable_d  = byteenable_q;
        owner_d       = owner_q;
        p0_done_d     = 1'b0;
        p1_done_d     = 1'b0;
        p0_readdata_d = p0_readdata_q;
        p1_readdata_d = p1_readdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_d      = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                read_d       = 1'b0;
                write_d      = 1'b0;
                address_d    = '0;
                writedata_d  = '0;
                byteenable_d = '0;
                if (p0_req || p1_req) begin
                    owner_d      = grant;
                    address_d    = grant ? p1_address    : p0_address;
                    writedata_d  = grant ? p1_writedata  : p0_writedata;
                    byteenable_d = grant ? p1_byteenable : p0_byteenable;
                    write_d      = sel_write;
                    read_d       = ~sel_write;
                    state_d      = BUS;
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    if (read_q) begin
                        if (owner_q) begin
                            p1_readdata_d = readdata;
                        end else begin
                            p0_readdata_d = readdata;
                        end
                    end
                    p0_done_d    = ~owner_q;
                    p1_done_d    = owner_q;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    address_d    = '0;
                    writedata_d  = '0;
                    byteenable_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_d     = owner_q;
`endif
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            address_q     <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            writedata_q   <= '0;
            byteenable_q  <= '0;
            owner_q       <= 1'b0;
            p0_done_q     <= 1'b0;
            p1_done_q     <= 1'b0;
            p0_readdata_q <= '0;
            p1_readdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            read_q        <= read_d;
            write_q       <= write_d;
            writedata_q   <= writedata_d;
            byteenable_q  <= byteenable_d;
            owner_q       <= owner_d;
            p0_done_q     <= p0_done_d;
            p1_done_q     <= p1_done_d;
            p0_readdata_q <= p0_readdata_d;
            p1_readdata_q <= p1_readdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q      <= rr_ptr_d;
`endif
        end
    end

    assign address     = address_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = writedata_q;
    assign byteenable  = byteenable_q;
    assign owner       = owner_q;
    assign p0_done     = p0_done_q;
    assign p1_done     = p1_done_q;
    assign p0_readdata = p0_readdata_q;
    assign p1_readdata = p1_readdata_q;
    assign busy        = (state_q == BUS) || (state_q == RESP);

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration and read results.
module tb_avalon_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_write, p1_req, p1_write;
    logic [31:0] p0_address, p0_writedata, p1_address, p1_writedata;
    logic [3:0]  p0_byteenable, p1_byteenable;
    logic        p0_done, p1_done;
    logic [31:0] p0_readdata, p1_readdata;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest, owner, busy;
    logic [3:0]  byteenable;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: preferred port on a tie, and each port's last read result.
    logic        m_pref;
    logic [31:0] m_rd0, m_rd1;

    avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_write(p0_write), .p0_address(p0_address),
        .p0_writedata(p0_writedata), .p0_byteenable(p0_byteenable),
        .p0_done(p0_done), .p0_readdata(p0_readdata),
        .p1_req(p1_req), .p1_write(p1_write), .p1_address(p1_address),
        .p1_writedata(p1_writedata), .p1_byteenable(p1_byteenable),
        .p1_done(p1_done), .p1_readdata(p1_readdata),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic pick(input logic r0, input logic r1);
        if (r0 && r1) return m_pref;
        return r1;
    endfunction

    task automatic note_done(input logic who);
`ifdef ARB_ROUND_ROBIN_EN
        m_pref = ~who;
`else
        m_pref = who | 1'b1;
`endif
    endtask

    task automatic clear_inputs();
        p0_req = 0; p0_write = 0; p0_address = 0; p0_writedata = 0; p0_byteenable = 0;
        p1_req = 0; p1_write = 0; p1_address = 0; p1_writedata = 0; p1_byteenable = 0;
        waitrequest = 0; readdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        m_pref = 1; m_rd0 = 0; m_rd1 = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        p0_req = 1; p1_req = 1; p1_address = 32'h1234; waitrequest = 1;
        reset = 1;
        @(negedge clk);
        n_cmp++;
        if ({read, write, busy, owner, p0_done, p1_done} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected 000000", {read, write, busy, owner, p0_done, p1_done});
        end
        n_cmp++;
        if ({address, writedata, byteenable, p0_readdata, p1_readdata} !== 132'b0) begin
            n_bad++; $display("FAIL reset_data: got %h expected 0", {address, writedata, byteenable, p0_readdata, p1_readdata});
        end
        clear_inputs();
        reset = 0;
        m_pref = 1; m_rd0 = 0; m_rd1 = 0;
        @(negedge clk);
    endtask

    task automatic test_p0_read();
        p0_req = 1; p0_write = 0; p0_address = 32'hBFC00000; p0_byteenable = 4'hF;
        waitrequest = 0; readdata = 32'h3C020005;
        @(negedge clk);
        n_cmp++;
        if ({read, write, busy, owner, address} !== {4'b1010, 32'hBFC00000}) begin
            n_bad++; $display("FAIL p0_read_cmd: got %h expected %h", {read, write, busy, owner, address}, {4'b1010, 32'hBFC00000});
        end
        @(negedge clk);
        n_cmp++;
        if ({read, p0_done, p1_done, p0_readdata} !== {3'b010, 32'h3C020005}) begin
            n_bad++; $display("FAIL p0_read_done: got %h expected %h", {read, p0_done, p1_done, p0_readdata}, {3'b010, 32'h3C020005});
        end
        m_rd0 = 32'h3C020005; note_done(1'b0);
        p0_req = 0; readdata = 32'hFFFF0000;
        @(negedge clk);
        n_cmp++;
        if ({p0_done, busy, p1_readdata} !== 34'b0) begin
            n_bad++; $display("FAIL p0_read_after: got %h expected 0", {p0_done, busy, p1_readdata});
        end
        @(negedge clk);
    endtask

    task automatic test_p1_write_wait();
        p1_req = 1; p1_write = 1; p1_address = 32'h00001000; p1_writedata = 32'hDEADBEEF;
        p1_byteenable = 4'hF; waitrequest = 1; readdata = 32'h55AA55AA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({write, read, p1_done, address, writedata, byteenable} !== {3'b100, 32'h1000, 32'hDEADBEEF, 4'hF}) begin
                n_bad++; $display("FAIL p1_write_stable[%0d]: got %h expected %h", i,
                    {write, read, p1_done, address, writedata, byteenable}, {3'b100, 32'h1000, 32'hDEADBEEF, 4'hF});
            end
        end
        waitrequest = 0;
        @(negedge clk);
        n_cmp++;
        if ({write, p1_done, p0_done, p1_readdata, p0_readdata} !== {3'b010, m_rd1, m_rd0}) begin
            n_bad++; $display("FAIL p1_write_done: got %h expected %h", {write, p1_done, p0_done, p1_readdata, p0_readdata}, {3'b010, m_rd1, m_rd0});
        end
        note_done(1'b1);
        p1_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({p1_done, busy} !== 2'b00) begin
            n_bad++; $display("FAIL p1_write_after: got %b expected 00", {p1_done, busy});
        end
        @(negedge clk);
    endtask

    task automatic test_both();
        int cnt;
        logic exp_first;
        exp_first = pick(1'b1, 1'b1);
        p0_req = 1; p0_write = 0; p0_address = 32'h100;
        p1_req = 1; p1_write = 0; p1_address = 32'h200;
        waitrequest = 0; readdata = exp_first ? 32'h11111111 : 32'h22222222;
        @(negedge clk);
        n_cmp++;
        if ({owner, read} !== {exp_first, 1'b1}) begin
            n_bad++; $display("FAIL both_first_owner: got %b expected %b", {owner, read}, {exp_first, 1'b1});
        end
        @(negedge clk);
        n_cmp++;
        if ({p1_done, p0_done} !== {exp_first, ~exp_first}) begin
            n_bad++; $display("FAIL both_first_done: got %b expected %b", {p1_done, p0_done}, {exp_first, ~exp_first});
        end
        if (exp_first) m_rd1 = readdata; else m_rd0 = readdata;
        note_done(exp_first);
        if (exp_first) p1_req = 0; else p0_req = 0;
        readdata = exp_first ? 32'h22222222 : 32'h11111111;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!(p0_done || p1_done) && cnt < 8);
        n_cmp++;
        if (cnt !== 3) begin
            n_bad++; $display("FAIL both_second_delay: got %0d cycles expected 3", cnt);
        end
        if (exp_first) m_rd0 = readdata; else m_rd1 = readdata;
        note_done(~exp_first);
        n_cmp++;
        if ({p0_readdata, p1_readdata} !== {m_rd0, m_rd1}) begin
            n_bad++; $display("FAIL both_readdata: got %h expected %h", {p0_readdata, p1_readdata}, {m_rd0, m_rd1});
        end
        p0_req = 0; p1_req = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int guard;
        logic win;
        p0_req = 1; p0_write = 0; p0_address = 32'h40;
        p1_req = 1; p1_write = 0; p1_address = 32'h80;
        waitrequest = 0;
        for (int t = 0; t < 4; t++) begin
            win = pick(1'b1, 1'b1);
            readdata = 32'hA0000000 + t;
            guard = 0;
            do begin @(negedge clk); guard++; end while (!(busy && (read || write)) && guard < 4);
            n_cmp++;
            if ({busy, owner} !== {1'b1, win}) begin
                n_bad++; $display("FAIL b2b_owner[%0d]: got %b expected %b", t, {busy, owner}, {1'b1, win});
            end
            @(negedge clk);
            if (win) m_rd1 = readdata; else m_rd0 = readdata;
            note_done(win);
            if (t == 3) begin p0_req = 0; p1_req = 0; end
        end
        n_cmp++;
        if ({p0_readdata, p1_readdata} !== {m_rd0, m_rd1}) begin
            n_bad++; $display("FAIL b2b_readdata: got %h expected %h", {p0_readdata, p1_readdata}, {m_rd0, m_rd1});
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        int pulses;
        p0_req = 1; p0_write = 0; p0_address = 32'h77; waitrequest = 1; readdata = 32'h0;
        @(negedge clk);
        p0_req = 0;
        @(negedge clk);
        @(negedge clk);
        waitrequest = 0; readdata = 32'hCAFEF00D;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (p0_done) pulses++;
        end
        m_rd0 = 32'hCAFEF00D; note_done(1'b0);
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++; $display("FAIL drop_req_pulses: got %0d expected 1", pulses);
        end
        n_cmp++;
        if ({p0_readdata, busy} !== {m_rd0, 1'b0}) begin
            n_bad++; $display("FAIL drop_req_data: got %h expected %h", {p0_readdata, busy}, {m_rd0, 1'b0});
        end
    endtask

    task automatic test_reset_mid_bus();
        int pulses;
        p0_req = 1; p0_write = 0; p0_address = 32'h99; waitrequest = 1;
        @(negedge clk);
        n_cmp++;
        if ({read, busy} !== 2'b11) begin
            n_bad++; $display("FAIL rst_mid_pre: got %b expected 11", {read, busy});
        end
        #1 reset = 1;
        #1;
        n_cmp++;
        if ({read, write, busy} !== 3'b000) begin
            n_bad++; $display("FAIL rst_mid_async: got %b expected 000", {read, write, busy});
        end
        clear_inputs();
        m_pref = 1; m_rd0 = 0; m_rd1 = 0;
        @(negedge clk);
        reset = 0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (p0_done || p1_done || busy) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++; $display("FAIL rst_mid_after: got %0d active cycles expected 0", pulses);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({read, write, busy, p0_done, p1_done} !== 5'b0) begin
                n_bad++; $display("FAIL idle[%0d]: got %b expected 00000", i, {read, write, busy, p0_done, p1_done});
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic r0, r1, win, exp_w;
            logic [31:0] rd, exp_a, exp_d;
            logic [3:0] exp_b;
            int w, guard;
            r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1;
            @(negedge clk);
            p0_req = r0; p0_write = 1'($urandom_range(0, 1)); p0_address = $urandom;
            p0_writedata = $urandom; p0_byteenable = 4'($urandom_range(1, 15));
            p1_req = r1; p1_write = 1'($urandom_range(0, 1)); p1_address = $urandom;
            p1_writedata = $urandom; p1_byteenable = 4'($urandom_range(1, 15));
            while (r0 || r1) begin
                win = pick(r0, r1);
                exp_w = win ? p1_write : p0_write;
                exp_a = win ? p1_address : p0_address;
                exp_d = win ? p1_writedata : p0_writedata;
                exp_b = win ? p1_byteenable : p0_byteenable;
                w = $urandom_range(0, 3);
                rd = $urandom;
                waitrequest = (w != 0);
                readdata = (w != 0) ? $urandom : rd;
                guard = 0;
                do begin @(negedge clk); guard++; end while (!(busy && (read || write)) && guard < 4);
                n_cmp++;
                if ({busy, owner, read, write, address, writedata, byteenable} !== {1'b1, win, ~exp_w, exp_w, exp_a, exp_d, exp_b}) begin
                    n_bad++; $display("FAIL rand_cmd[%0d]: got %h expected %h", it,
                        {busy, owner, read, write, address, writedata, byteenable}, {1'b1, win, ~exp_w, exp_w, exp_a, exp_d, exp_b});
                end
                for (int j = 0; j < w; j++) begin
                    readdata = $urandom;
                    @(negedge clk);
                    n_cmp++;
                    if ({p0_done, p1_done, read, write, address} !== {2'b00, ~exp_w, exp_w, exp_a}) begin
                        n_bad++; $display("FAIL rand_wait[%0d]: got %h expected %h", it,
                            {p0_done, p1_done, read, write, address}, {2'b00, ~exp_w, exp_w, exp_a});
                    end
                end
                waitrequest = 0; readdata = rd;
                @(negedge clk);
                if (!exp_w) begin
                    if (win) m_rd1 = rd; else m_rd0 = rd;
                end
                note_done(win);
                n_cmp++;
                if ({p0_done, p1_done, read, write, p0_readdata, p1_readdata} !== {~win, win, 2'b00, m_rd0, m_rd1}) begin
                    n_bad++; $display("FAIL rand_done[%0d]: got %h expected %h", it,
                        {p0_done, p1_done, read, write, p0_readdata, p1_readdata}, {~win, win, 2'b00, m_rd0, m_rd1});
                end
                if (win) begin p1_req = 0; r1 = 0; end
                else begin p0_req = 0; r0 = 0; end
            end
            @(negedge clk);
            n_cmp++;
            if ({busy, p0_done, p1_done} !== 3'b000) begin
                n_bad++; $display("FAIL rand_idle[%0d]: got %b expected 000", it, {busy, p0_done, p1_done});
            end
        end
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        m_pref = 1; m_rd0 = 0; m_rd1 = 0;
        clear_inputs();
        reset = 1;
        test_reset();
        test_idle();
        test_p0_read();
        test_p1_write_wait();
        test_both();
        test_back_to_back();
        test_drop_req();
        test_reset_mid_bus();
        do_reset();
        test_random();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
